// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operand/control sequencer:
// ALUControl encodings and the sequencer state type.
package alu_pkg;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command handshake and completion bus between a command source and the
// ALU operand sequencer.
interface alu_op_sequencer_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_ldi;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_rd;
    logic [ADDR_W-1:0] cmd_ra;
    logic [ADDR_W-1:0] cmd_rb;
    logic [WIDTH-1:0]  cmd_imm;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic              zero_flag;

    modport master (
        output cmd_valid, cmd_ldi, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm,
        input  cmd_ready, done, result, zero_flag
    );

    modport slave (
        input  cmd_valid, cmd_ldi, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm,
        output cmd_ready, done, result, zero_flag
    );
endinterface

// File: rtl/alu_op_sequencer_regfile.sv
// NREGS x WIDTH register file: two operand read ports, one debug read port,
// one synchronous write port, asynchronous active-low clear.
module alu_regfile #(
    parameter int WIDTH  = 8,
    parameter int NREGS  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]  ra_data,
    output logic [WIDTH-1:0]  rb_data,
    output logic [WIDTH-1:0]  dbg_data
);

    logic [WIDTH-1:0] mem_r [NREGS];

    // Storage: cleared on reset, single write port otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign ra_data  = mem_r[ra_addr];
    assign rb_data  = mem_r[rb_addr];
    assign dbg_data = mem_r[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Operand/control stage in front of the 8-bit ALU: accepts ALU and
// load-immediate commands, drives registered operands, writes results back.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NREGS  = 4,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    alu_op_sequencer_if.slave cmd,
    output logic [WIDTH-1:0]  SrcA,
    output logic [WIDTH-1:0]  SrcB,
    output logic [1:0]        ALUControl,
    input  logic [WIDTH-1:0]  ALUResult,
    input  logic              Zero,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);

    state_t            state_r;
    state_t            state_s;
    logic              accept_s;
    logic              we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [WIDTH-1:0]  wdata_s;
    logic              wzero_s;
    logic [ADDR_W-1:0] rd_r;
    logic [WIDTH-1:0]  srca_r;
    logic [WIDTH-1:0]  srcb_r;
    logic [1:0]        aluctl_r;
    logic              done_r;
    logic [WIDTH-1:0]  result_r;
    logic              zero_flag_r;
    logic [WIDTH-1:0]  rdata_a_s;
    logic [WIDTH-1:0]  rdata_b_s;

    assign cmd.cmd_ready = (state_r == IDLE);
    assign accept_s      = cmd.cmd_valid && (state_r == IDLE);

    alu_regfile #(
        .WIDTH  (WIDTH),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (we_s),
        .waddr    (waddr_s),
        .wdata    (wdata_s),
        .ra_addr  (cmd.cmd_ra),
        .rb_addr  (cmd.cmd_rb),
        .dbg_addr (dbg_addr),
        .ra_data  (rdata_a_s),
        .rb_data  (rdata_b_s),
        .dbg_data (dbg_data)
    );

    // Next state and writeback select: LDI writes at its accept edge, ALU ops at the EXEC edge.
    always_comb begin
        state_s = state_r;
        we_s    = 1'b0;
        waddr_s = cmd.cmd_rd;
        wdata_s = cmd.cmd_imm;
        wzero_s = (cmd.cmd_imm == {WIDTH{1'b0}});
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (cmd.cmd_ldi) begin
                        we_s = 1'b1;
                    end else begin
                        state_s = EXEC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                we_s    = 1'b1;
                waddr_s = rd_r;
                wdata_s = ALUResult;
                wzero_s = Zero;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, latched operands and completion status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            rd_r        <= {ADDR_W{1'b0}};
            srca_r      <= {WIDTH{1'b0}};
            srcb_r      <= {WIDTH{1'b0}};
            aluctl_r    <= 2'b00;
            done_r      <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            zero_flag_r <= 1'b0;
        end else begin
            state_r <= state_s;
            done_r  <= we_s;
            if (accept_s && !cmd.cmd_ldi) begin
                srca_r   <= rdata_a_s;
                srcb_r   <= rdata_b_s;
                aluctl_r <= cmd.cmd_op;
                rd_r     <= cmd.cmd_rd;
            end
            if (we_s) begin
                result_r    <= wdata_s;
                zero_flag_r <= wzero_s;
            end
        end
    end

    assign SrcA          = srca_r;
    assign SrcB          = srcb_r;
    assign ALUControl    = aluctl_r;
    assign cmd.done      = done_r;
    assign cmd.result    = result_r;
    assign cmd.zero_flag = zero_flag_r;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Control/operand stage that sits directly upstream of the 8-bit ALU.
- Accepts register-to-register ALU commands and load-immediate commands over a valid/ready handshake.
- Holds a small register file, drives SrcA/SrcB/ALUControl to the ALU, and samples ALUResult/Zero. It writes the result back to the register file and reports completion.

Parameters:
- WIDTH, 8, data width; must match the ALU operand width.
- NREGS, 4, register file depth; ADDR_W = $clog2(NREGS) (2 at default).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command this cycle
- cmd_ldi  in  1  1 = load immediate into rd; 0 = ALU operation
- cmd_op  in  2  ALU operation, same encoding as ALUControl
- cmd_rd  in  ADDR_W  destination register
- cmd_ra  in  ADDR_W  source register A
- cmd_rb  in  ADDR_W  source register B
- cmd_imm  in  WIDTH  immediate for load-immediate
- SrcA  out  WIDTH  registered ALU operand A
- SrcB  out  WIDTH  registered ALU operand B
- ALUControl  out  2  registered ALU operation select
- ALUResult  in  WIDTH  ALU result, combinational from SrcA/SrcB/ALUControl
- Zero  in  1  ALU zero flag
- done  out  1  one-cycle pulse: a command has completed and been written back
- result  out  WIDTH  last written-back value
- zero_flag  out  1  zero status of last written-back value
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  WIDTH  combinational read of rf[dbg_addr]

Behaviour:
- States: IDLE, EXEC.
- cmd_ready = (state == IDLE), combinational; it is 1 while in reset.
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - All rf entries, SrcA, SrcB, ALUControl and result go to 0.
  - zero_flag and done go to 0.
- A command is accepted only on a rising edge with cmd_valid & cmd_ready. cmd_valid while not ready is ignored and not queued; the source must hold it.
- Load-immediate, accepted at edge N:
  - At edge N: rf[cmd_rd] <= cmd_imm, result <= cmd_imm, zero_flag <= (cmd_imm == 0), done <= 1.
  - State stays IDLE and the ALU outputs are untouched.
  - done is high in cycle N+1. Back-to-back load-immediates are accepted every cycle.
- ALU operation, accepted at edge N:
  - At edge N: SrcA <= rf[cmd_ra], SrcB <= rf[cmd_rb], ALUControl <= cmd_op, rd is latched, state -> EXEC.
  - In cycle N+1 (EXEC), the ALU inputs are stable and the ALU settles combinationally.
  - At edge N+1: rf[rd] <= ALUResult, result <= ALUResult, zero_flag <= Zero, done <= 1, state -> IDLE.
  - done is high in cycle N+2, and the next command can be accepted at edge N+2. Throughput is one ALU op per 2 cycles.
- done is 0 in every cycle not listed above.
- SrcA, SrcB and ALUControl hold their last values between operations.
- ALUResult and Zero are sampled only at the EXEC edge and ignored otherwise.
- Operand reads use the register file state before the accepting edge. Every write completes before the next accept, so no hazard logic is needed; a command always sees all prior results.
- ra == rb == rd is legal; the old value is read and the new value written.
- All registers, including r0, are writable; there is no hardwired zero.
- Arithmetic is WIDTH bits, modulo 2^WIDTH, as performed by the ALU. The sequencer does no arithmetic.
- reset_n asserted during EXEC aborts the operation: no writeback, no done pulse, all state cleared.

Decomposition:
- Package alu_pkg holds:
  - the ALUControl encodings ALU_AND=2'b00, ALU_OR=2'b01, ALU_ADD=2'b10, ALU_SUB=2'b11;
  - the state enum {IDLE, EXEC}.
- One sub-module, alu_regfile: NREGS x WIDTH, two combinational read ports plus a debug read port, one synchronous write port, asynchronous active-low clear.

Test Plan:
(Bench instantiates the existing ALU connected to SrcA/SrcB/ALUControl/ALUResult/Zero.)
1. Reset, then release -> cmd_ready=1, done=0, dbg_data=0x00 for all four registers, zero_flag=0.
2. LDI r1=0x05 then LDI r2=0x03 on consecutive cycles -> done high in each following cycle; dbg r1=0x05, r2=0x03; result=0x03.
3. ADD rd=r3, ra=r1, rb=r2 accepted at edge N -> SrcA=0x05, SrcB=0x03, ALUControl=2'b10 and cmd_ready=0 in cycle N+1; done, result=0x08, zero_flag=0 and r3=0x08 in cycle N+2.
4. SUB r0=r1-r1 -> result=0x00, zero_flag=1. Then LDI r2=0xFF, LDI r1=0x01, ADD r3=r2+r1 -> result=0x00 (wrap), zero_flag=1. AND/OR of 0xF0, 0x3C -> 0x30 and 0xFC respectively.
5. cmd_valid held high across an ADD's EXEC cycle with a second command -> second command accepted exactly once, at the IDLE edge, and it reads the first command's written-back value.
6. reset_n dropped mid-cycle during EXEC of ADD r3=r1+r2 -> immediately state IDLE, all regs 0x00, no done pulse, r3 not written.
